// File: rtl/mem_copy_dma.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_copy_dma: word-granular block-copy engine, master on data-memory port |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_copy_dma #(
    parameter int DEPTH_WORDS = 64,
    parameter int LEN_W       = 7
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [31:0]      src_i32,
    input  logic [31:0]      dst_i32,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o32,
    output logic [31:0]      mem_wdata_o32,
    input  logic [31:0]      mem_rdata_i32
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [32:0] c_depth = 33'(DEPTH_WORDS);

    state_t           r_state;
    state_t           w_state_nx;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_idx;
    logic [31:0]      r_hold;
    logic             r_err;

    logic [LEN_W-1:0] w_idx_nx;
    logic [31:0]      w_off;
    logic [32:0]      w_src_end;
    logic [32:0]      w_dst_end;
    logic             w_req_err;

    // End-of-region word indices in 33 bits so a huge base cannot wrap past the check.
    assign w_src_end = {3'b000, src_i32[31:2]} + {{(33-LEN_W){1'b0}}, len_i};
    assign w_dst_end = {3'b000, dst_i32[31:2]} + {{(33-LEN_W){1'b0}}, len_i};
    assign w_req_err = (src_i32[1:0] != 2'b00) || (dst_i32[1:0] != 2'b00) ||
                       (w_src_end > c_depth) || (w_dst_end > c_depth);

    assign w_idx_nx = r_idx + 1'b1;
    assign w_off    = {{(30-LEN_W){1'b0}}, r_idx, 2'b00};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_src  <= '0;
            r_dst  <= '0;
            r_len  <= '0;
            r_idx  <= '0;
            r_hold <= '0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_src  <= src_i32;
                        r_dst  <= dst_i32;
                        r_len  <= len_i;
                        r_idx  <= '0;
                        r_hold <= '0;
                        r_err  <= w_req_err;
                    end
                end
                S_READ:  r_hold <= mem_rdata_i32;
                S_WRITE: r_idx  <= w_idx_nx;
                S_DONE:  r_err  <= 1'b0;
                default: r_err  <= 1'b0;
            endcase
        end
    end

    // Memory outputs depend on registered state only, so start_i never reaches the port.
    always_comb begin
        w_state_nx    = r_state;
        busy_o        = 1'b0;
        done_o        = 1'b0;
        err_o         = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o32  = '0;
        mem_wdata_o32 = '0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nx = (w_req_err || (len_i == '0)) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                busy_o       = 1'b1;
                mem_addr_o32 = r_src + w_off;
                w_state_nx   = S_WRITE;
            end
            S_WRITE: begin
                busy_o        = 1'b1;
                mem_we_o      = 1'b1;
                mem_addr_o32  = r_dst + w_off;
                mem_wdata_o32 = r_hold;
                w_state_nx    = (w_idx_nx == r_len) ? S_DONE : S_READ;
            end
            S_DONE: begin
                done_o     = 1'b1;
                err_o      = r_err;
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_dma.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_copy_dma: scoreboard bench for mem_copy_dma with a 64-word memory  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mem_copy_dma;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] src, dst;
    logic [6:0]  len;
    logic        busy, done, err, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [64];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int bsy_cnt = 0;

    typedef struct packed {
        logic err;
        int   e0;
        int   lat;
        int   wr;
        int   bsy;
    } exp_t;
    exp_t sb [$];

    mem_copy_dma #(.DEPTH_WORDS(64), .LEN_W(7)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
        .src_i32(src), .dst_i32(dst), .len_i(len),
        .busy_o(busy), .done_o(done), .err_o(err),
        .mem_we_o(mem_we), .mem_addr_o32(mem_addr), .mem_wdata_o32(mem_wdata),
        .mem_rdata_i32(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
        else if (pre_we) mem[pre_addr] <= pre_data;
    end

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            wr_cnt  = 0;
            bsy_cnt = 0;
        end else begin
            if (mem_we) wr_cnt++;
            if (busy) bsy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
                end else begin
                    e = sb.pop_front();
                    n_cmp++;
                    if (err !== e.err) begin
                        n_fail++;
                        $display("FAIL done_err: got %b required %b", err, e.err);
                    end
                    n_cmp++;
                    if (cyc - e.e0 != e.lat) begin
                        n_fail++;
                        $display("FAIL done_latency: got %0d required %0d", cyc - e.e0, e.lat);
                    end
                    n_cmp++;
                    if (wr_cnt != e.wr) begin
                        n_fail++;
                        $display("FAIL write_count: got %0d required %0d", wr_cnt, e.wr);
                    end
                    n_cmp++;
                    if (bsy_cnt != e.bsy) begin
                        n_fail++;
                        $display("FAIL busy_cycles: got %0d required %0d", bsy_cnt, e.bsy);
                    end
                end
                wr_cnt  = 0;
                bsy_cnt = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic poke(input int a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = 6'(a); pre_data = d;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    // Drives start for one edge; returns at the negedge of cycle 1 after E0.
    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [6:0] l,
                            input bit expect_done, input logic e_err, input int e_lat,
                            input int e_wr, input int e_bsy);
        exp_t e;
        @(negedge clk);
        start = 1'b1; src = s; dst = d; len = l;
        if (expect_done) begin
            e.err = e_err; e.e0 = cyc; e.lat = e_lat; e.wr = e_wr; e.bsy = e_bsy;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0; src = 32'hDEAD_BEE0; dst = 32'hDEAD_BEE0; len = 7'd5;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: got %0d pending responses required 0", name, sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 64; i++) poke(i, 32'd0);
        for (int i = 0; i < 4; i++) poke(i, 32'hA0 + 32'(i));

        // Basic 4-word copy to words 16..19.
        do_start(32'h00, 32'h40, 7'd4, 1'b1, 1'b0, 9, 4, 8);
        wait_done("copy4");
        for (int i = 0; i < 4; i++) check("copy4_mem", mem[16+i], 32'hA0 + 32'(i));

        // Zero length.
        do_start(32'h00, 32'h40, 7'd0, 1'b1, 1'b0, 1, 0, 0);
        wait_done("len0");
        check("len0_mem", mem[16], 32'hA0);

        // Rejections: misaligned source, then source range overflow.
        do_start(32'h02, 32'h40, 7'd1, 1'b1, 1'b1, 1, 0, 0);
        wait_done("misalign");
        do_start(32'hF8, 32'h00, 7'd3, 1'b1, 1'b1, 1, 0, 0);
        wait_done("range");
        check("range_mem0", mem[0], 32'hA0);

        // Overlapping forward copy smears word 0 upward.
        poke(0, 32'h1); poke(1, 32'h2); poke(2, 32'h3);
        do_start(32'h00, 32'h04, 7'd3, 1'b1, 1'b0, 7, 3, 6);
        wait_done("overlap");
        for (int i = 1; i < 4; i++) check("overlap_mem", mem[i], 32'h1);

        // Start pulses while busy and in DONE are ignored.
        for (int i = 0; i < 4; i++) poke(i, 32'hB0 + 32'(i));
        for (int i = 16; i < 20; i++) poke(i, 32'd0);
        do_start(32'h00, 32'h40, 7'd4, 1'b1, 1'b0, 9, 4, 8);
        @(negedge clk);
        start = 1'b1; src = 32'h20; dst = 32'h60; len = 7'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        start = 1'b1; src = 32'h20; dst = 32'h60; len = 7'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore");
        for (int i = 0; i < 4; i++) check("ignore_mem", mem[16+i], 32'hB0 + 32'(i));
        check("ignore_mem24", mem[24], 32'd0);
        check("ignore_mem25", mem[25], 32'd0);

        // Exact fit at the top of memory is accepted.
        do_start(32'h00, 32'hF0, 7'd4, 1'b1, 1'b0, 9, 4, 8);
        wait_done("topfit");
        for (int i = 0; i < 4; i++) check("topfit_mem", mem[60+i], 32'hB0 + 32'(i));

        // Reset during the write of word 2 aborts the copy.
        do_start(32'h00, 32'h80, 7'd4, 1'b0, 1'b0, 0, 0, 0);
        repeat (5) @(negedge clk);
        check("abort_pre_we", {31'd0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_we", {31'd0, mem_we}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_addr", mem_addr, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_mem32", mem[32], 32'hB0);
        check("abort_mem33", mem[33], 32'hB1);
        check("abort_mem34", mem[34], 32'd0);
        check("abort_mem35", mem[35], 32'd0);

        do_start(32'h00, 32'h80, 7'd4, 1'b1, 1'b0, 9, 4, 8);
        wait_done("restart");
        for (int i = 0; i < 4; i++) check("restart_mem", mem[32+i], 32'hB0 + 32'(i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
